// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM states, instruction field positions and decode helpers.
package core_pkg;

  typedef enum logic [0:0] {
    FETCH_OP  = 1'b0,
    FETCH_IMM = 1'b1
  } fetch_state_e;

  localparam int OPC_MSB     = 15;
  localparam int OPC_LSB     = 11;
  localparam int RDST_MSB    = 10;
  localparam int RDST_LSB    = 8;
  localparam int RSRC_MSB    = 7;
  localparam int RSRC_LSB    = 5;
  localparam int HAS_IMM_BIT = 0;

  localparam logic [15:0] NOP_WORD = 16'h0000;

  function automatic logic has_imm(input logic [15:0] word);
    return word[HAS_IMM_BIT];
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: a bubble clears it, a load captures a complete instruction,
// otherwise it holds.
module if_id_reg #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bubble,
  input  logic                   load,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic [INSTR_WIDTH-1:0] imm_in,
  input  logic [PC_WIDTH-1:0]    pc_next_in,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [INSTR_WIDTH-1:0] imm,
  output logic [PC_WIDTH-1:0]    pc_next,
  output logic                   valid
);

  logic [INSTR_WIDTH-1:0] instr_d, instr_q;
  logic [INSTR_WIDTH-1:0] imm_d, imm_q;
  logic [PC_WIDTH-1:0]    pc_next_d, pc_next_q;
  logic                   valid_d, valid_q;

  // Bubble beats load; with neither the register keeps its contents.
  always_comb begin
    instr_d   = instr_q;
    imm_d     = imm_q;
    pc_next_d = pc_next_q;
    valid_d   = valid_q;
    if (bubble) begin
      instr_d   = {INSTR_WIDTH{1'b0}};
      imm_d     = {INSTR_WIDTH{1'b0}};
      pc_next_d = {PC_WIDTH{1'b0}};
      valid_d   = 1'b0;
    end else if (load) begin
      instr_d   = instr_in;
      imm_d     = imm_in;
      pc_next_d = pc_next_in;
      valid_d   = 1'b1;
    end else begin
      valid_d   = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q   <= {INSTR_WIDTH{1'b0}};
      imm_q     <= {INSTR_WIDTH{1'b0}};
      pc_next_q <= {PC_WIDTH{1'b0}};
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      imm_q     <= imm_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
    end
  end

  assign instr   = instr_q;
  assign imm     = imm_q;
  assign pc_next = pc_next_q;
  assign valid   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, two-state opcode/immediate assembly FSM and the IF/ID register.
module fetch_stage
  import core_pkg::*;
#(
  parameter int                 PC_WIDTH     = 32,
  parameter int                 INSTR_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pc_write,
  input  logic                   stall_fetch,
  input  logic                   flush_fetch,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [INSTR_WIDTH-1:0] if_id_imm,
  output logic [PC_WIDTH-1:0]    if_id_pc_next,
  output logic                   if_id_valid,
  output logic [2:0]             r_dest_fetch,
  output logic [2:0]             r_src_fetch
);

  fetch_state_e           state_d, state_q;
  logic [PC_WIDTH-1:0]    pc_d, pc_q;
  logic [INSTR_WIDTH-1:0] hold_d, hold_q;
  logic [PC_WIDTH-1:0]    pc_inc;
  logic                   hold_req;

  logic                   ifid_bubble;
  logic                   ifid_load;
  logic [INSTR_WIDTH-1:0] ifid_instr;
  logic [INSTR_WIDTH-1:0] ifid_imm;

  assign hold_req = stall_fetch | ~pc_write;
  assign pc_inc   = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH_OP;
      pc_q    <= RESET_VECTOR;
      hold_q  <= {INSTR_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  // Next state: flush redirects and drops any half-assembled instruction, even under hold.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    if (flush_fetch) begin
      state_d = FETCH_OP;
      pc_d    = branch_target;
      hold_d  = {INSTR_WIDTH{1'b0}};
    end else if (hold_req) begin
      state_d = state_q;
    end else begin
      pc_d = pc_inc;
      case (state_q)
        FETCH_OP: begin
          if (has_imm(imem_rdata)) begin
            state_d = FETCH_IMM;
            hold_d  = imem_rdata;
          end else begin
            state_d = FETCH_OP;
          end
        end
        FETCH_IMM: state_d = FETCH_OP;
        default:   state_d = FETCH_OP;
      endcase
    end
  end

  always_comb begin
    ifid_bubble = 1'b0;
    ifid_load   = 1'b0;
    ifid_instr  = imem_rdata;
    ifid_imm    = {INSTR_WIDTH{1'b0}};
    if (flush_fetch) begin
      ifid_bubble = 1'b1;
    end else if (hold_req) begin
      ifid_load = 1'b0;
    end else begin
      case (state_q)
        FETCH_OP: begin
          if (has_imm(imem_rdata)) begin
            ifid_bubble = 1'b1;
          end else begin
            ifid_load = 1'b1;
          end
        end
        FETCH_IMM: begin
          ifid_load  = 1'b1;
          ifid_instr = hold_q;
          ifid_imm   = imem_rdata;
        end
        default: ifid_bubble = 1'b1;
      endcase
    end
  end

  if_id_reg #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .bubble     (ifid_bubble),
    .load       (ifid_load),
    .instr_in   (ifid_instr),
    .imm_in     (ifid_imm),
    .pc_next_in (pc_inc),
    .instr      (if_id_instr),
    .imm        (if_id_imm),
    .pc_next    (if_id_pc_next),
    .valid      (if_id_valid)
  );

  assign imem_addr    = pc_q;
  assign r_dest_fetch = if_id_instr[RDST_MSB:RDST_LSB];
  assign r_src_fetch  = if_id_instr[RSRC_MSB:RSRC_LSB];

endmodule
